tone_gen: RTL and testbench
===========================

Name: tone_gen

Overview:
- Downstream consumer of the note-to-frequency stage. Accepts one note per handshake: an integer frequency in Hz plus a duration in ms.
- Converts the frequency to a half-period cycle count with an iterative divider, then drives a 50%-duty square wave on `audio` for the duration.
- Follows each note with a fixed silent gap, then reports completion.
- Sits between the sequencer/frequency stage and the speaker pin.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz; must be ≥1000 and a multiple of 1000.
- GAP_MS, 10, silence after each note in ms; 0 allowed (no gap).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  note request
- in_ready  out  1  block can accept a note
- freq  in  20  note frequency, integer Hz; 0 = rest
- dur_ms  in  16  note duration in ms
- audio  out  1  square-wave output
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse when a note and its gap finish

Behaviour:
- Reset values (clk edge with rst=1): state IDLE, audio=0, done=0, busy=0, all counters 0; in_ready=1 from the first cycle after reset.
- Reset mid-operation aborts immediately: no done pulse, audio=0 on the next cycle.
- MS_CYCLES = CLK_HZ/1000 (constant).
- States:
  - IDLE:
    - in_ready=1.
    - Accept when in_valid & in_ready (cycle T0): latch freq, dur_ms.
    - If dur_ms==0: stay IDLE, pulse done at T0+1.
    - Else if freq==0: go to PLAY as a rest, skipping DIV; PLAY starts T0+1.
    - Else: go to DIV.
    - in_valid while not in IDLE is ignored; inputs are sampled only at acceptance.
  - DIV:
    - Restoring divider, one quotient bit per cycle, 32 cycles (T0+1..T0+32).
    - Dividend CLK_HZ (32 b), divisor 2*freq (21 b).
    - HALF = floor(CLK_HZ / (2*freq)); if HALF==0, clamp HALF=1.
    - Go to PLAY at T0+33.
  - PLAY:
    - Lasts exactly dur_ms*MS_CYCLES cycles; 32-bit cycle counter, no overflow for 16-bit dur_ms with the default CLK_HZ.
    - Tone: audio=1 in the first PLAY cycle, held HALF cycles, then toggles every HALF cycles.
    - Rest: audio=0 throughout.
    - On expiry go to GAP, or to IDLE directly if GAP_MS==0; audio=0 in that cycle, mid-period truncation allowed.
  - GAP:
    - audio=0 for GAP_MS*MS_CYCLES cycles, then IDLE.
- done is high for exactly the first IDLE cycle after GAP/PLAY completes. in_ready is also 1 that cycle, so a new note may be accepted in the same cycle as done (back-to-back).
- in_ready = (state==IDLE) & ~rst. busy = (state≠IDLE).
- All outputs are registered except in_ready and busy, which decode state only.

Test Plan (CLK_HZ=100_000, GAP_MS=1, MS_CYCLES=100):
- Reset: rst high 3 cycles with in_valid=1 -> audio=0, done=0, busy=0, no acceptance; in_ready=1 on the first cycle after rst drops.
- freq=440, dur_ms=2, accepted at T0:
  - HALF=113.
  - audio high T0+33..T0+145, low T0+146..T0+232.
  - audio=0 during GAP T0+233..T0+332.
  - done=1 at T0+333 only; busy low at T0+333.
- freq=0, dur_ms=1 -> PLAY T0+1..T0+100 with audio=0, GAP T0+101..T0+200, done at T0+201.
- freq=60000 (HALF clamps to 1), dur_ms=1 -> audio toggles every cycle for 100 cycles starting high at T0+33, then 0.
- dur_ms=0, freq=440 -> no tone, busy never high, done at T0+1.
- Back-to-back with reset:
  - Hold in_valid=1, freq=1000 during a note: second note is accepted exactly on the done cycle; no extra acceptance while busy.
  - rst asserted mid-PLAY: audio=0 next cycle, no done, in_ready=1 after release.

Source files
------------

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - square-wave tone generator driven by frequency/duration note requests
//
// Purpose: accepts one note (frequency in Hz, duration in ms) per handshake,
// derives the half-period in clock cycles with a 32-step restoring divider,
// plays a 50%-duty square wave for the note duration, then a fixed silent gap.
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   in_valid  note request
//   in_ready  block can accept a note (idle and not in reset)
//   freq      note frequency in Hz, 0 = rest
//   dur_ms    note duration in ms, 0 = no note (immediate done)
//   audio     square-wave output (registered)
//   busy      high whenever not idle
//   done      one-cycle pulse when a note and its gap have finished (registered)
module tone_gen #(
   parameter int CLK_HZ = 50_000_000,
   parameter int GAP_MS = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [19:0] freq,
   input  logic [15:0] dur_ms,
   output logic        audio,
   output logic        busy,
   output logic        done
);

   localparam int          MS_CYCLES  = CLK_HZ / 1000;
   localparam logic [31:0] MS_CYC32   = 32'(MS_CYCLES);
   localparam logic [31:0] DIVIDEND   = 32'(CLK_HZ);
   localparam logic [31:0] GAP_CYCLES = 32'(GAP_MS * MS_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIV,
      S_PLAY,
      S_GAP
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [19:0] r_freq;
   logic [20:0] r_rem;
   logic [31:0] r_dq;      // dividend shifts out the top while quotient bits shift in
   logic [4:0]  r_bit;
   logic [31:0] r_half;
   logic [31:0] r_hcnt;
   logic [31:0] r_cnt;     // cycles remaining in PLAY or GAP
   logic        r_rest;

   logic        w_accept;
   logic        w_div_last;
   logic        w_play_last;
   logic        w_gap_last;
   logic        w_done_next;
   logic [21:0] w_rem_sh;
   logic [20:0] w_divisor;
   logic        w_qbit;
   logic [20:0] w_rem_diff;
   logic [31:0] w_quo;
   logic [31:0] w_half;

   assign in_ready = (r_state == S_IDLE) & ~rst;
   assign busy     = (r_state != S_IDLE);
   assign w_accept = in_valid & in_ready;

   assign w_div_last  = (r_state == S_DIV)  && (r_bit == 5'd31);
   assign w_play_last = (r_state == S_PLAY) && (r_cnt == 32'd1);
   assign w_gap_last  = (r_state == S_GAP)  && (r_cnt == 32'd1);

   // One restoring-division step; the remainder always stays below the divisor,
   // so the 21-bit difference is exact whenever the subtraction is taken.
   assign w_divisor  = {r_freq, 1'b0};
   assign w_rem_sh   = {r_rem, r_dq[31]};
   assign w_qbit     = (w_rem_sh >= {1'b0, w_divisor});
   assign w_rem_diff = w_rem_sh[20:0] - w_divisor;
   assign w_quo      = {r_dq[30:0], w_qbit};
   assign w_half     = (w_quo == 32'd0) ? 32'd1 : w_quo;

   always_comb begin
      w_state_next = r_state;
      w_done_next  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (dur_ms == 16'd0) begin
                  w_done_next = 1'b1;
               end else if (freq == 20'd0) begin
                  w_state_next = S_PLAY;
               end else begin
                  w_state_next = S_DIV;
               end
            end
         end
         S_DIV: begin
            if (w_div_last) begin
               w_state_next = S_PLAY;
            end
         end
         S_PLAY: begin
            if (w_play_last) begin
               if (GAP_MS == 0) begin
                  w_state_next = S_IDLE;
                  w_done_next  = 1'b1;
               end else begin
                  w_state_next = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (w_gap_last) begin
               w_state_next = S_IDLE;
               w_done_next  = 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_freq <= '0;
         r_rem  <= '0;
         r_dq   <= '0;
         r_bit  <= '0;
         r_half <= '0;
         r_hcnt <= '0;
         r_cnt  <= '0;
         r_rest <= 1'b0;
         audio  <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= w_done_next;
         case (r_state)
            S_IDLE: begin
               audio <= 1'b0;
               if (w_accept) begin
                  r_freq <= freq;
                  r_cnt  <= 32'(dur_ms) * MS_CYC32;
                  r_rem  <= '0;
                  r_dq   <= DIVIDEND;
                  r_bit  <= '0;
                  r_rest <= (freq == 20'd0);
               end
            end
            S_DIV: begin
               r_rem <= w_qbit ? w_rem_diff : w_rem_sh[20:0];
               r_dq  <= w_quo;
               r_bit <= r_bit + 5'd1;
               if (w_div_last) begin
                  r_half <= w_half;
                  r_hcnt <= w_half - 32'd1;
                  audio  <= 1'b1;
               end
            end
            S_PLAY: begin
               if (w_play_last) begin
                  audio <= 1'b0;
                  r_cnt <= GAP_CYCLES;
               end else begin
                  r_cnt <= r_cnt - 32'd1;
                  if (!r_rest) begin
                     if (r_hcnt == 32'd0) begin
                        audio  <= ~audio;
                        r_hcnt <= r_half - 32'd1;
                     end else begin
                        r_hcnt <= r_hcnt - 32'd1;
                     end
                  end
               end
            end
            S_GAP: begin
               audio <= 1'b0;
               r_cnt <= r_cnt - 32'd1;
            end
            default: audio <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_tone_gen.sv
// tb/tb_tone_gen.sv - directed self-checking bench for tone_gen
module tb_tone_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] freq;
   logic [15:0] dur_ms;
   logic        audio;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;

   tone_gen #(
      .CLK_HZ(100_000),
      .GAP_MS(1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .freq    (freq),
      .dur_ms  (dur_ms),
      .audio   (audio),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // advance one clock and sample mid-cycle
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issue one note at T0 and check audio/busy/done on every cycle T0+1..T0+done_at+1.
   // ps = first PLAY cycle, total = PLAY length, half = hand-computed HALF.
   task automatic run_note(input string name, input logic [19:0] f, input logic [15:0] d,
                           input int ps, input int half, input int total,
                           input int done_at, input bit rest);
      logic exp_audio;
      in_valid = 1'b1;
      freq     = f;
      dur_ms   = d;
      check($sformatf("%s_accept_rdy", name), 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      for (int k = 1; k <= done_at + 1; k++) begin
         exp_audio = 1'b0;
         if (!rest && k >= ps && k < ps + total)
            exp_audio = (((k - ps) / half) % 2) == 0;
         check($sformatf("%s_audio_T%0d", name, k), 32'(audio), 32'(exp_audio));
         check($sformatf("%s_busy_T%0d", name, k), 32'(busy), 32'(k < done_at));
         check($sformatf("%s_done_T%0d", name, k), 32'(done), 32'(k == done_at));
         if (k != done_at + 1) step();
      end
   endtask

   initial begin
      logic exp_audio;
      logic saw_done;
      rst      = 1'b1;
      in_valid = 1'b1;
      freq     = 20'd440;
      dur_ms   = 16'd2;

      // reset with in_valid held: nothing accepted
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("rst_audio_%0d", i), 32'(audio), 32'd0);
         check($sformatf("rst_done_%0d", i), 32'(done), 32'd0);
         check($sformatf("rst_busy_%0d", i), 32'(busy), 32'd0);
         check($sformatf("rst_ready_%0d", i), 32'(in_ready), 32'd0);
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      check("post_rst_ready", 32'(in_ready), 32'd1);
      step();
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_ready2", 32'(in_ready), 32'd1);

      // 440 Hz, 2 ms: HALF=113, PLAY T0+33..T0+232, GAP ..T0+332, done T0+333
      run_note("n440", 20'd440, 16'd2, 33, 113, 200, 333, 1'b0);
      step();
      // rest, 1 ms: PLAY T0+1..T0+100, GAP ..T0+200, done T0+201
      run_note("rest", 20'd0, 16'd1, 1, 1, 100, 201, 1'b1);
      step();
      // 60 kHz clamps HALF to 1: toggles every cycle from T0+33 for 100 cycles
      run_note("clamp", 20'd60000, 16'd1, 33, 1, 100, 233, 1'b0);
      step();
      // zero duration: done at T0+1, never busy
      run_note("dur0", 20'd440, 16'd0, 1, 1, 0, 1, 1'b0);
      step();

      // back-to-back with in_valid held: note 1 done at T0+233, note 2 accepted there
      in_valid = 1'b1;
      freq     = 20'd1000;
      dur_ms   = 16'd1;
      check("b2b_accept_rdy", 32'(in_ready), 32'd1);
      for (int k = 1; k <= 300; k++) begin
         step();
         exp_audio = 1'b0;
         if (k >= 33 && k < 133)  exp_audio = (((k - 33) / 50) % 2) == 0;
         if (k >= 266 && k < 366) exp_audio = (((k - 266) / 50) % 2) == 0;
         check($sformatf("b2b_audio_T%0d", k), 32'(audio), 32'(exp_audio));
         check($sformatf("b2b_busy_T%0d", k), 32'(busy), 32'(k != 233));
         check($sformatf("b2b_done_T%0d", k), 32'(done), 32'(k == 233));
      end
      // reset mid-PLAY of note 2 (audio high at T0+300)
      rst = 1'b1;
      step();
      check("midrst_audio", 32'(audio), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_ready", 32'(in_ready), 32'd0);
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      check("midrst_ready_after", 32'(in_ready), 32'd1);
      saw_done = 1'b0;
      for (int k = 0; k < 150; k++) begin
         step();
         if (done || busy || audio) saw_done = 1'b1;
      end
      check("midrst_quiet_after", 32'(saw_done), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
